aes_ctr_xor_out_stage: RTL and testbench

//  Final stage of the AES-256-CTR datapath, directly feeding the ciphertext AXI-Stream sink.
//  - Joins the plaintext stream with the keystream stream, one word each per transfer.
//  - XORs each pair and emits ciphertext through a 2-entry skid buffer.
//  - Keeps per-packet word and packet counters.

---
 rtl/aes_ctr_xor_out_stage.sv | 155 +++++++++++++++
 tb/tb_aes_ctr_xor_out_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_xor_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctr_xor_out_stage
// Description : AES-CTR output stage. Joins plaintext and keystream, XORs them
//               and drives the ciphertext stream through a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_ctr_xor_out_stage #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_pt_tdata,
    input  logic                  s_pt_tvalid,
    input  logic                  s_pt_tlast,
    output logic                  s_pt_tready,
    input  logic [DATA_WIDTH-1:0] s_ks_tdata,
    input  logic                  s_ks_tvalid,
    output logic                  s_ks_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  word_idx,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  pkt_done
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  r_main_last;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic [CNT_WIDTH-1:0]  r_word_idx;
    logic [CNT_WIDTH-1:0]  r_pkt_count;
    logic                  r_pkt_done;

    logic                  w_space;
    logic                  w_join;
    logic                  w_take;
    logic                  w_load_main_new;
    logic                  w_load_main_skid;
    logic                  w_load_skid;
    logic [DATA_WIDTH-1:0] w_ct;

    // Input readiness depends only on registered state, never on m_axis_tready.
    assign w_space     = (r_state != ST_FULL);
    assign w_join      = s_pt_tvalid & s_ks_tvalid & w_space;
    assign w_take      = m_axis_tvalid & m_axis_tready;
    assign w_ct        = s_pt_tdata ^ s_ks_tdata;

    assign s_pt_tready = w_space & s_ks_tvalid;
    assign s_ks_tready = w_space & s_pt_tvalid;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_join) begin
                    w_load_main_new = 1'b1;
                    w_state_nxt     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_join && w_take) begin
                    w_load_main_new = 1'b1;
                end else if (w_join) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_take) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_take) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_main_last <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else begin
            if (w_load_main_new) begin
                r_main_data <= w_ct;
                r_main_last <= s_pt_tlast;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_last <= r_skid_last;
            end
            if (w_load_skid) begin
                r_skid_data <= w_ct;
                r_skid_last <= s_pt_tlast;
            end
        end
    end

    // Counters follow the output handshake; wrap is intentional.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_idx  <= '0;
            r_pkt_count <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= w_take & r_main_last;
            if (w_take) begin
                if (r_main_last) begin
                    r_word_idx  <= '0;
                    r_pkt_count <= r_pkt_count + c_CNT_ONE;
                end else begin
                    r_word_idx  <= r_word_idx + c_CNT_ONE;
                end
            end
        end
    end

    assign m_axis_tvalid = (r_state != ST_EMPTY);
    assign m_axis_tdata  = r_main_data;
    assign m_axis_tlast  = r_main_last;
    assign word_idx      = r_word_idx;
    assign pkt_count     = r_pkt_count;
    assign pkt_done      = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_xor_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_ctr_xor_out_stage
// Description : Scoreboard bench for the AES-CTR XOR output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_ctr_xor_out_stage;

    localparam int DW = 128;
    localparam int CW = 32;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_pt_tdata = '0;
    logic          s_pt_tvalid = 1'b0;
    logic          s_pt_tlast = 1'b0;
    logic          s_pt_tready;
    logic [DW-1:0] s_ks_tdata = '0;
    logic          s_ks_tvalid = 1'b0;
    logic          s_ks_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [CW-1:0] word_idx;
    logic [CW-1:0] pkt_count;
    logic          pkt_done;

    aes_ctr_xor_out_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_pt_tdata   (s_pt_tdata),
        .s_pt_tvalid  (s_pt_tvalid),
        .s_pt_tlast   (s_pt_tlast),
        .s_pt_tready  (s_pt_tready),
        .s_ks_tdata   (s_ks_tdata),
        .s_ks_tvalid  (s_ks_tvalid),
        .s_ks_tready  (s_ks_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .word_idx     (word_idx),
        .pkt_count    (pkt_count),
        .pkt_done     (pkt_done)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_done   = 0;
    item_t         pt_q[$];
    logic [DW-1:0] ks_q[$];
    item_t         exp_q[$];

    function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endfunction

    // Reference: ciphertext is plaintext XOR keystream, in issue order.
    task automatic add_word(logic [DW-1:0] pt, logic [DW-1:0] ks, logic last);
        pt_q.push_back('{d: pt, l: last});
        ks_q.push_back(ks);
        exp_q.push_back('{d: pt ^ ks, l: last});
    endtask

    task automatic drive(bit pe, bit ke, bit rdy);
        if (!s_pt_tvalid && pe && pt_q.size() > 0) begin
            s_pt_tvalid = 1'b1;
            s_pt_tdata  = pt_q[0].d;
            s_pt_tlast  = pt_q[0].l;
        end
        if (!s_ks_tvalid && ke && ks_q.size() > 0) begin
            s_ks_tvalid = 1'b1;
            s_ks_tdata  = ks_q[0];
        end
        m_axis_tready = rdy;
    endtask

    task automatic tick();
        bit pf;
        bit kf;
        @(negedge clk);
        pf = s_pt_tvalid & s_pt_tready;
        kf = s_ks_tvalid & s_ks_tready;
        if (pf || kf) chk("join_atomic", DW'(pf), DW'(kf));
        @(posedge clk);
        #1;
        if (pf) begin
            void'(pt_q.pop_front());
            s_pt_tvalid = 1'b0;
        end
        if (kf) begin
            void'(ks_q.pop_front());
            s_ks_tvalid = 1'b0;
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            drive(1'b1, 1'b1, 1'b1);
            tick();
            n++;
        end
        chk("drain_pending", DW'(exp_q.size()), '0);
        repeat (2) begin
            drive(1'b0, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_tvalid"}, DW'(m_axis_tvalid), '0);
        chk({tag, "_tdata"}, m_axis_tdata, '0);
        chk({tag, "_tlast"}, DW'(m_axis_tlast), '0);
        chk({tag, "_word_idx"}, DW'(word_idx), '0);
        chk({tag, "_pkt_count"}, DW'(pkt_count), '0);
        chk({tag, "_pkt_done"}, DW'(pkt_done), '0);
    endtask

    // Monitor: pops expected words on every output handshake.
    initial begin : monitor
        int            m_word;
        int            m_pkt;
        bit            done_next;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        item_t         e;
        m_word = 0; m_pkt = 0; done_next = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_word = 0; m_pkt = 0; done_next = 0; prev_stall = 0;
            end else begin
                chk("pkt_done", DW'(pkt_done), DW'(done_next));
                if (pkt_done) n_done++;
                if (prev_stall) begin
                    chk("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
                    chk("hold_tdata", m_axis_tdata, prev_data);
                    chk("hold_tlast", DW'(m_axis_tlast), DW'(prev_last));
                end
                done_next = 0;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL spurious_word got=%h expected=none", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ct_data", m_axis_tdata, e.d);
                        chk("ct_last", DW'(m_axis_tlast), DW'(e.l));
                        chk("word_idx", DW'(word_idx), DW'(m_word));
                        chk("pkt_count", DW'(pkt_count), DW'(m_pkt));
                        if (e.l) begin
                            m_word = 0;
                            m_pkt++;
                            done_next = 1;
                        end else begin
                            m_word++;
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    initial begin : stimulus
        int pkts;
        logic last;
        #1;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4-word packet, constant keystream
        for (int i = 0; i < 4; i++)
            add_word(DW'(i), {16{8'hA5}}, (i == 3));
        drain(20);
        chk("stream_pkt_count", DW'(pkt_count), DW'(1));
        chk("stream_pkt_done_pulses", DW'(n_done), DW'(1));

        // Keystream held off: no lone transfer, then one-cycle latency
        add_word({4{$urandom}}, {4{$urandom}}, 1'b1);
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b1);
            #1;
            chk("skew_pt_tready", DW'(s_pt_tready), '0);
            chk("skew_no_out", DW'(m_axis_tvalid), '0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1);
        #1;
        chk("skew_join_ready", DW'(s_pt_tready & s_ks_tready), DW'(1));
        chk("skew_no_out_yet", DW'(m_axis_tvalid), '0);
        tick();
        chk("skew_latency_valid", DW'(m_axis_tvalid), DW'(1));
        chk("skew_latency_data", m_axis_tdata, s_pt_tdata ^ s_ks_tdata);
        drain(20);

        // Backpressure fills the skid buffer
        for (int i = 0; i < 6; i++)
            add_word({4{$urandom}}, {4{$urandom}}, (i == 5));
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0);
        #1;
        m_axis_tready = 1'b1;
        #1;
        chk("one_ready_no_comb_path", DW'(s_pt_tready), DW'(1));
        m_axis_tready = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b0);
            #1;
            chk("full_pt_tready", DW'(s_pt_tready), '0);
            chk("full_ks_tready", DW'(s_ks_tready), '0);
            if (c == 0) begin
                m_axis_tready = 1'b1;
                #1;
                chk("full_no_comb_path", DW'(s_pt_tready | s_ks_tready), '0);
                m_axis_tready = 1'b0;
            end
            tick();
        end
        drain(40);

        // Three single-word packets back to back
        for (int i = 0; i < 3; i++)
            add_word({4{$urandom}}, {4{$urandom}}, 1'b1);
        drain(20);
        chk("single_pkt_count", DW'(pkt_count), DW'(6));
        chk("single_pkt_done_pulses", DW'(n_done), DW'(6));
        chk("single_word_idx", DW'(word_idx), '0);

        // Random valid/ready traffic
        pkts = 6;
        for (int i = 0; i < 3000; i++) begin
            last = (i == 2999) || ($urandom_range(0, 4) == 0);
            if (last) pkts++;
            add_word({4{$urandom}}, {4{$urandom}}, last);
        end
        for (int c = 0; c < 40000 && exp_q.size() > 0; c++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        drain(50);
        chk("random_pkt_count", DW'(pkt_count), DW'(pkts));
        chk("random_pkt_done_pulses", DW'(n_done), DW'(pkts));

        // Asynchronous reset with a full buffer
        for (int i = 0; i < 3; i++)
            add_word({4{$urandom}}, {4{$urandom}}, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0);
        tick();
        chk("pre_rst_full", DW'(s_pt_tready), '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        pt_q.delete();
        ks_q.delete();
        exp_q.delete();
        s_pt_tvalid = 1'b0;
        s_ks_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b1);
            #1;
            chk("post_rst_tvalid", DW'(m_axis_tvalid), '0);
            tick();
        end
        chk("post_rst_pkt_count", DW'(pkt_count), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
